// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter driving a shared 8:1 mux select, one-hot grant and valid/ready, with capped locked bursts.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module mux8_rr_arbiter #(
  parameter int NREQ      = 8,
  parameter int SEL_W     = 3,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  lock,
  input  logic             out_ready,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n, base, pick, rel_ptr;
  logic [NREQ-1:0]  gnt_n, others, mask;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W:0]   cnt_inc;
  logic             found, xfer, stay, forced, rel;
  assign busy      = state == GRANT;
  assign out_valid = busy && req[sel];
  assign xfer      = out_valid && out_ready;
  assign cnt_inc   = {1'b0, burst_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign stay      = xfer && lock[sel] && (cnt_inc < (CNT_W+1)'(MAX_BURST));
  assign forced    = xfer && lock[sel] && !(cnt_inc < (CNT_W+1)'(MAX_BURST));
  assign rel       = busy && (!req[sel] || (xfer && !stay));
  assign others    = req & ~(NREQ'(1) << sel);
  // Only a forced release excludes the current holder from arbitration.
  assign mask      = forced ? others : req;
`ifdef MUX_ARB_FIXED_PRIO_EN
  assign base    = '0;
  assign rel_ptr = ptr;
`else
  assign rel_ptr = sel + SEL_W'(1);
  assign base    = busy ? rel_ptr : ptr;
`endif
  always_comb begin
    found = 1'b0;
    pick  = base;
    for (int k = NREQ-1; k >= 0; k--)
      if (mask[base + SEL_W'(k)]) begin
        found = 1'b1;
        pick  = base + SEL_W'(k);
      end
  end
  always_comb begin
    state_n = state;
    sel_n   = sel;
    gnt_n   = gnt;
    ptr_n   = ptr;
    cnt_n   = burst_cnt;
    if (!busy) begin
      if (found) begin
        state_n = GRANT;
        sel_n   = pick;
        gnt_n   = NREQ'(1) << pick;
      end
    end else if (rel) begin
      ptr_n = rel_ptr;
      cnt_n = '0;
      if (|others) begin
        sel_n = pick;
        gnt_n = NREQ'(1) << pick;
      end else if (!forced) begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    end else if (stay) begin
      cnt_n = (burst_cnt == CNT_W'(MAX_BURST)) ? burst_cnt : cnt_inc[CNT_W-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sel       <= '0;
      gnt       <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      gnt       <= gnt_n;
      ptr       <= ptr_n;
      burst_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed self-checking bench for mux8_rr_arbiter.
module tb_mux8_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, lock, gnt;
  logic       out_ready, out_valid, busy;
  logic [2:0] sel;
  logic [3:0] burst_cnt;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  mux8_rr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .out_ready(out_ready),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .busy(busy), .burst_cnt(burst_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b0; req = 8'hFF; lock = 8'h00; out_ready = 1'b1;
    tick(); tick();
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_sel", {5'd0, sel}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_cnt", {4'd0, burst_cnt}, 8'd0);
    rst = 1'b1;
    tick();
    chk("first_gnt", gnt, 8'h01);
    chk("first_busy", {7'd0, busy}, 8'd1);
`ifdef MUX_ARB_FIXED_PRIO_EN
    req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fp_hold0", gnt, 8'h01);
    end
    req = 8'h80;
    tick();
    chk("fp_gnt7", gnt, 8'h80);
    chk("fp_sel7", {5'd0, sel}, 8'd7);
`else
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("rr_sel", {5'd0, sel}, 8'(i % 8));
      chk("rr_gnt", gnt, 8'(1 << (i % 8)));
    end
    for (int i = 0; i < 6; i++) tick();
    chk("to6_sel", {5'd0, sel}, 8'd6);
    req = 8'h05;
    tick(); chk("sparse_0a", gnt, 8'h01);
    tick(); chk("sparse_2", gnt, 8'h04);
    tick(); chk("sparse_0b", gnt, 8'h01);
    req = 8'h09; lock = 8'h01;
    chk("lk_cnt0", {4'd0, burst_cnt}, 8'd0);
    tick(); chk("lk_cnt1", {4'd0, burst_cnt}, 8'd1); chk("lk_sel1", {5'd0, sel}, 8'd0);
    tick(); chk("lk_cnt2", {4'd0, burst_cnt}, 8'd2);
    tick(); chk("lk_cnt3", {4'd0, burst_cnt}, 8'd3); chk("lk_sel3", {5'd0, sel}, 8'd0);
    tick(); chk("lk_rel_gnt", gnt, 8'h08); chk("lk_rel_cnt", {4'd0, burst_cnt}, 8'd0);
    req = 8'h01;
    tick(); chk("regnt0", gnt, 8'h01); chk("regnt0_cnt", {4'd0, burst_cnt}, 8'd0);
    tick(); tick(); tick();
    chk("solo_cnt3", {4'd0, burst_cnt}, 8'd3);
    tick();
    chk("solo_gnt", gnt, 8'h01);
    chk("solo_busy", {7'd0, busy}, 8'd1);
    chk("solo_cnt", {4'd0, burst_cnt}, 8'd0);
    req = 8'h00; lock = 8'h00;
    tick();
    chk("idle_gnt", gnt, 8'h00);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_sel", {5'd0, sel}, 8'd0);
    req = 8'h08; out_ready = 1'b0;
    tick(); chk("st_gnt3", gnt, 8'h08); chk("st_sel3", {5'd0, sel}, 8'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_hold", gnt, 8'h08);
      chk("st_cnt", {4'd0, burst_cnt}, 8'd0);
      chk("st_valid", {7'd0, out_valid}, 8'd1);
    end
    req = 8'h20;
    tick(); chk("wd_gnt5", gnt, 8'h20); chk("wd_sel5", {5'd0, sel}, 8'd5);
    req = 8'h00;
    tick(); chk("wd_idle", gnt, 8'h00); chk("wd_sel_hold", {5'd0, sel}, 8'd5);
    req = 8'h21; out_ready = 1'b1;
    tick(); chk("ptr6_wrap", gnt, 8'h01);
    rst = 1'b0;
    tick();
    chk("mid_rst_gnt", gnt, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_sel", {5'd0, sel}, 8'd0);
    rst = 1'b1;
    tick(); chk("post_rst_gnt", gnt, 8'h01);
    tick(); chk("post_rst_next", gnt, 8'h20);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-input datapath mux between eight requesters.
- Drives the 3-bit select of the shared 8:1 mux and a one-hot grant vector.
- Performs a valid/ready handshake with the downstream consumer.
- Supports locked bursts, capped at a parameterised beat count, so one requester can hold the path for multi-beat transfers without starving the others.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 to match the 3-bit mux select.
- SEL_W, 3, select width.
- MAX_BURST, 4, maximum beats one requester may hold a locked grant before a forced release; range 1..15.
- CNT_W, 4, burst counter width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising clk edge.
- req  input  8  per-requester request, level; bit i = requester i.
- lock  input  8  per-requester burst lock; sampled only for the granted requester.
- out_ready  input  1  downstream accepts the current beat.
- gnt  output  8  one-hot grant; all zero when idle.
- sel  output  3  select to the shared 8:1 mux; equals the index of the set gnt bit.
- out_valid  output  1  downstream beat valid.
- busy  output  1  high while in GRANT.
- burst_cnt  output  4  beats transferred in the current grant.

Behaviour:
- Reset (rst=0 at a clk edge):
  - gnt=0, sel=0, out_valid=0, busy=0, burst_cnt=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - Reset applied mid-grant aborts the transfer with no completion.
- State IDLE:
  - gnt=0 and out_valid=0; sel holds its last value.
  - If req!=0, select the first set bit scanning ptr, ptr+1, ... with modulo-8 wrap.
  - Register gnt/sel at the next edge and go to GRANT.
  - Latency from req assertion to gnt is exactly 1 cycle.
- State GRANT, grant held by index g:
  - busy=1; out_valid = req[g], combinational from registered g.
  - Beat transfer = out_valid && out_ready; burst_cnt increments per beat, saturating at MAX_BURST.
- On a transfer, in priority order:
  - lock[g]=1, req[g]=1 and burst_cnt+1 < MAX_BURST: stay granted to g with sel unchanged.
  - Otherwise release: ptr=g+1 mod 8 and burst_cnt=0. If any requester other than g has req set, arbitrate directly in the same cycle; the new gnt appears next cycle with no IDLE bubble. Otherwise go to IDLE.
- Forced release at MAX_BURST:
  - g is excluded from that arbitration only.
  - If g is the sole requester, it is re-granted next cycle with burst_cnt=0.
- Withdrawal (req[g] drops while granted with no transfer):
  - Release as above with ptr=g+1; no beat is counted.
- Stall (out_ready=0 with req[g]=1): hold gnt, sel and burst_cnt indefinitely.
- Requests rising while granted wait for arbitration; they never preempt g.
- gnt is always one-hot or zero, and sel always matches gnt when gnt!=0.
- Simultaneous requests resolve strictly by ptr order.

Optional Feature:
- MUX_ARB_FIXED_PRIO_EN defined:
  - Arbitration scans from index 0 upward (0 highest priority); ptr is ignored and not updated.
  - Lock and MAX_BURST rules still apply, and forced release still excludes g for one arbitration.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: rst=0 for 2 cycles with req=8'hFF -> gnt=0, sel=0, out_valid=0, busy=0; after rst=1, gnt=8'h01 one cycle later.
- Round-robin: req=8'hFF, lock=0, out_ready=1 constantly -> sel sequence 0,1,2,...,7,0 on consecutive cycles with no bubbles.
- Wrap and sparse: after a grant to 6, req=8'h05 -> grant 0, then 2, then 0.
- Locked burst, MAX_BURST=4: req=8'h09, lock[0]=1, out_ready=1 -> 4 beats on sel=0 (burst_cnt 0..3), then gnt=8'h08; with req=8'h01 only, re-grant to 0 with burst_cnt=0.
- Stall and withdraw: grant 3, out_ready=0 for 5 cycles -> gnt stays 8'h08 and burst_cnt stays 0; then req[3]=0 with req[5]=1 -> gnt=8'h20 next cycle and ptr=4.
- Fixed priority (macro defined): req=8'h81, out_ready=1, lock=0 -> index 0 granted every arbitration; index 7 is served only after req[0] drops.
